// File: rtl/inst_fetch.sv
// inst_fetch: PC sequencer feeding a 2-entry {pc, instr} fetch buffer
// with branch redirect, halt and ready/valid hand-off to decode.
module inst_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    output logic [7:0]  imem_addr,
    input  logic [15:0] imem_data,
    input  logic        br_valid,
    input  logic [7:0]  br_target,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_instr,
    output logic [7:0]  out_pc,
    output logic [1:0]  buf_count
);
    logic [7:0]  pc_q, pc_d;
    logic [1:0]  cnt_q, cnt_d, rem;
    logic [23:0] e0_q, e0_d, e1_q, e1_d;
    logic        pop, push;
    always_comb begin
        pop   = (cnt_q != 2'd0) && out_ready;
        push  = !halt && !br_valid && (cnt_q != 2'd2 || pop);
        rem   = cnt_q - {1'b0, pop};
        e0_d  = pop ? e1_q : e0_q;
        e1_d  = e1_q;
        pc_d  = pc_q;
        cnt_d = rem + {1'b0, push};
        if (push) begin
            if (rem == 2'd0) e0_d = {pc_q, imem_data};
            else e1_d = {pc_q, imem_data};
            pc_d = pc_q + 8'd1;
        end
        // a redirect discards everything, including a concurrent pop
        if (br_valid) begin
            cnt_d = 2'd0;
            pc_d  = br_target;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            cnt_q <= 2'd0;
            e0_q  <= 24'd0;
            e1_q  <= 24'd0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            e0_q  <= e0_d;
            e1_q  <= e1_d;
        end
    end
    assign imem_addr = pc_q;
    assign buf_count = cnt_q;
    assign out_valid = cnt_q != 2'd0;
    assign out_pc    = out_valid ? e0_q[23:16] : 8'd0;
    assign out_instr = out_valid ? e0_q[15:0] : 16'd0;
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 8'h00, giving the PC value loaded at reset.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port imem_addr, output, 8 bits: address to the 256x16 instruction memory, whose read is combinational.
REQ-005 The block SHALL have port imem_data, input, 16 bits: instruction word returned in the same cycle for imem_addr.
REQ-006 The block SHALL have port br_valid, input, 1 bit: single-cycle redirect request.
REQ-007 The block SHALL have port br_target, input, 8 bits: redirect address, sampled when br_valid=1.
REQ-008 The block SHALL have port halt, input, 1 bit: level-sensitive fetch stop.
REQ-009 The block SHALL have port out_valid, output, 1 bit: head of the fetch buffer is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the decode stage accepts the head entry.
REQ-011 The block SHALL have port out_instr, output, 16 bits: instruction at the buffer head.
REQ-012 The block SHALL have port out_pc, output, 8 bits: address of out_instr.
REQ-013 The block SHALL have port buf_count, output, 2 bits: number of occupied buffer entries (0..2).

Function
REQ-014 The block SHALL hold an 8-bit PC register and SHALL drive imem_addr = PC continuously.
REQ-015 The block SHALL hold a 2-entry FIFO of {pc[7:0], instr[15:0]}, and out_valid, out_instr and out_pc SHALL reflect the FIFO head.
REQ-016 When the FIFO is empty, out_valid SHALL be 0 and out_instr and out_pc SHALL be 0.
REQ-017 A pop SHALL occur on a rising edge when out_valid=1 and out_ready=1.
REQ-018 The push condition is fetch_en = !halt && !br_valid && (buf_count<2 || pop); when fetch_en=1, the block SHALL write {PC, imem_data} at the FIFO tail and set PC <= PC+1 on that edge.
REQ-019 PC increment SHALL wrap modulo 256 (8'hFF -> 8'h00) with no flag and no stall.
REQ-020 If push and pop occur on the same edge, the block SHALL perform both, leaving buf_count unchanged, including when buf_count=2.
REQ-021 When buf_count=2 and there is no pop, the block SHALL neither push nor advance the PC.
REQ-022 When br_valid=1 on an edge, the block SHALL flush the FIFO (buf_count <= 0), set PC <= br_target, and perform no push; a concurrent pop SHALL be discarded.
REQ-023 br_valid SHALL have priority over halt, pop and push.
REQ-024 While halt=1 and br_valid=0, the block SHALL hold the PC and perform no push, and the FIFO SHALL continue to drain through pops.
REQ-025 Fetch latency SHALL be 1 cycle: an instruction fetched at edge N SHALL be visible at the head after edge N if the FIFO was empty.
REQ-026 With out_ready held at 1 and no halt or branch, the block SHALL deliver one instruction per cycle with consecutive PCs.
REQ-027 After a redirect, the first instruction at br_target SHALL appear at the head one edge after the redirect edge, giving 2 cycles from br_valid assertion to the target on out_*.

Reset
REQ-028 While rst=1, the block SHALL force PC=RESET_PC, buf_count=0, out_valid=0, out_instr=0, out_pc=0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.
REQ-029 When rst asserts mid-operation, the block SHALL discard all buffered entries and any pending redirect.
REQ-030 The first push after rst deasserts SHALL occur on the first rising edge with fetch_en=1.

Verification
REQ-031 The bench SHALL cover: memory preloaded rom[i]=16'hA000+i, RESET_PC=0, out_ready=1 -> out_pc 0,1,2,... with out_instr A000,A001,... on consecutive cycles, and out_valid=1 from the first edge after reset.
REQ-032 The bench SHALL cover: out_ready=0 for 5 cycles -> buf_count saturates at 2, PC stops at 2, and entries for pc 0 and 1 are retained; then out_ready=1 -> pc 0,1,2,3 delivered with no gap or duplicate.
REQ-033 The bench SHALL cover: br_valid=1, br_target=8'h40 while buf_count=2 and out_ready=1 -> the next edge gives buf_count=0 and out_valid=0, and the following edge gives out_pc=8'h40 and out_instr=A040.
REQ-034 The bench SHALL cover: br_target=8'hFE with free-running fetch -> out_pc FE, FF, 00, 01 (wrap-around).
REQ-035 The bench SHALL cover: halt=1 with buf_count=2 and out_ready=1 -> two entries drained, then out_valid=0 with PC held; halt=0 -> fetch resumes at the held PC.
REQ-036 The bench SHALL cover: rst pulsed between clock edges mid-stream -> outputs zero immediately, imem_addr=RESET_PC, and after release the sequence restarts at RESET_PC.
